reservoir_mac: RTL
==================

Name: reservoir_mac

Overview:
- Sequential signed multiply-accumulate stage directly downstream of the reservoir weight ROM.
- Consumes the flattened weight bus (element j at bits [(j+1)*weight_size-1 : j*weight_size]) and a reservoir state vector packed the same way.
- Produces one neuron pre-activation sum, sum over j of w[j]*s[j], using one multiplier time-shared over reservoir_size cycles.
- Result feeds the activation/state-update stage via a one-cycle valid pulse.

Parameters:
- weight_size, 32: bit width of each signed weight element.
- state_size, 32: bit width of each signed state element.
- reservoir_size, 3: number of elements (N); must be >= 1.
- acc_size, 64: signed accumulator/result width; must be >= weight_size+state_size.

Ports:
- iClk  input  1  clock, rising edge.
- iReset  input  1  asynchronous, active-high reset.
- iStart  input  1  start request; sampled only when oBusy=0.
- iWeights  input  weight_size*reservoir_size  flattened signed weights (from weight ROM).
- iStates  input  state_size*reservoir_size  flattened signed state vector.
- oBusy  output  1  high while a computation is in progress.
- oValid  output  1  one-cycle pulse; oResult valid while high.
- oResult  output  acc_size  signed sum; holds its value until the next oValid.
- oSat  output  1  high with oValid if saturation occurred (tied 0 without the macro).

Behaviour:
- Interface: one clock iClk; iReset is asynchronous and active-high.
- Reset: state=IDLE, idx=0, acc=0, oBusy=0, oValid=0, oResult=0, oSat=0, latched vectors=0. Reset asserted mid-RUN aborts the computation; no oValid is produced for it.
- FSM states: IDLE and RUN.
- IDLE:
  - oBusy=0.
  - On an edge with iStart=1: latch iWeights and iStates into internal registers, set acc=0, idx=0, sat flag=0, go to RUN.
  - Inputs may change freely after this edge.
- RUN:
  - oBusy=1.
  - Each edge: prod = sext(w[idx]) * sext(s[idx]), full signed product; acc_next = acc + sext(prod) at acc_size; idx++.
  - On the edge where idx==N-1: oResult<=acc_next, oValid<=1, oSat<=flag, state<=IDLE, oBusy<=0.
- Latency: iStart sampled at edge E0; oValid is high in the cycle after edge E0+N. Throughput is one result per N+1 cycles.
- oValid is high exactly one cycle and is cleared by the next edge.
- iStart in the same cycle oValid is high is accepted (oBusy=0), so back-to-back operation runs with no gap cycle.
- iStart while oBusy=1 is ignored: no queueing, no effect on the current computation.
- N=1: RUN lasts one edge; oValid appears in the cycle after E0+1.
- Arithmetic: all values are two's complement; the product width is weight_size+state_size before sign extension. With the macro off, overflow wraps modulo 2^acc_size.

Optional Feature:
- Macro: RESERVOIR_MAC_SATURATE_EN.
- Defined:
  - Each accumulate step checks for signed overflow (operands share a sign and the sum's sign differs).
  - On overflow, acc clamps to +(2^(acc_size-1)-1) or -(2^(acc_size-1)) and the sticky sat flag is set.
  - Later steps continue from the clamped value.
  - oSat reports the flag alongside oValid.
- Undefined:
  - Wrap-around arithmetic, no overflow logic synthesized.
  - oSat is constant 0.

Test Plan:
- Defaults, weights {1,2,3}, states {4,5,6}, iStart one cycle -> oBusy high 3 cycles, oValid pulses once in the cycle after the 3rd RUN edge, oResult=32, oSat=0.
- Signed case: weights {-2,3,0}, states {7,-1,100} -> oResult=-17 (0xFFFF_FFFF_FFFF_FFEF).
- weight_size=8, state_size=8, acc_size=16, all weights and states 127 -> with macro: oResult=32767, oSat=1; without macro: oResult=-17149, oSat=0.
- Back-to-back and busy behaviour:
  - iStart held high continuously -> results every 4 cycles, oValid never high in consecutive cycles.
  - Extra iStart pulse mid-RUN -> ignored; oResult unchanged from the expected value.
- Input change after start: change iWeights to all 0 one cycle after an accepted iStart -> oResult still equals the sum computed from the latched values (32 in the first case).
- Reset mid-operation: assert iReset asynchronously between edges during RUN -> oBusy, oValid, oResult, oSat go 0 immediately, no oValid follows; the next iStart gives a correct result.

Source files
------------

// File: rtl/reservoir_mac.sv
// reservoir_mac: sequential signed multiply-accumulate over one reservoir row.
// One multiplier is time-shared over reservoir_size cycles; the result leaves
// with a one-cycle valid pulse.
// Optional feature: define RESERVOIR_MAC_SATURATE_EN to clamp the accumulator
// on signed overflow and report it on oSat (otherwise wrap-around, oSat = 0).
module reservoir_mac #(
   parameter int unsigned weight_size    = 32,
   parameter int unsigned state_size     = 32,
   parameter int unsigned reservoir_size = 3,
   parameter int unsigned acc_size       = 64
) (
   input  logic                                   iClk,
   input  logic                                   iReset,
   input  logic                                   iStart,
   input  logic [weight_size*reservoir_size-1:0]  iWeights,
   input  logic [state_size*reservoir_size-1:0]   iStates,
   output logic                                   oBusy,
   output logic                                   oValid,
   output logic [acc_size-1:0]                    oResult,
   output logic                                   oSat
);

   localparam int unsigned prod_size = weight_size + state_size;
   localparam int unsigned idx_w     = (reservoir_size > 1) ? $clog2(reservoir_size) : 1;
   localparam logic [idx_w-1:0] last_idx = idx_w'(reservoir_size - 1);

   typedef enum logic [0:0] {StIdle, StRun} state_t;

   state_t state_q, state_d;

   logic [weight_size*reservoir_size-1:0] w_q;
   logic [state_size*reservoir_size-1:0]  s_q;
   logic [idx_w-1:0]                      idx_q;
   logic signed [acc_size-1:0]            acc_q;
   logic [acc_size-1:0]                   result_q;
   logic                                  valid_q;

   logic                                  load;
   logic                                  step;
   logic                                  done;

   logic signed [weight_size-1:0]         w_sel;
   logic signed [state_size-1:0]          s_sel;
   logic signed [prod_size-1:0]           w_ext;
   logic signed [prod_size-1:0]           s_ext;
   logic signed [prod_size-1:0]           prod;
   logic signed [acc_size-1:0]            prod_ext;
   logic signed [acc_size-1:0]            sum;
   logic signed [acc_size-1:0]            acc_next;

`ifdef RESERVOIR_MAC_SATURATE_EN
   localparam logic [acc_size-1:0] acc_max = {1'b0, {(acc_size-1){1'b1}}};
   localparam logic [acc_size-1:0] acc_min = {1'b1, {(acc_size-1){1'b0}}};
   logic sat_q;
   logic osat_q;
   logic sat_next;
   logic ovf;
`endif

   // Next-state and control decode for the IDLE/RUN sequencer
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (iStart) begin
               load    = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            step = 1'b1;
            if (idx_q == last_idx) begin
               done    = 1'b1;
               state_d = StIdle;
            end
         end
      endcase
   end

   // Element select, full-width signed product and accumulate step
   always_comb begin
      w_sel = '0;
      s_sel = '0;
      for (int j = 0; j < int'(reservoir_size); j++) begin
         if (idx_q == idx_w'(j)) begin
            w_sel = w_q[j*weight_size +: weight_size];
            s_sel = s_q[j*state_size +: state_size];
         end
      end
      w_ext    = prod_size'(w_sel);
      s_ext    = prod_size'(s_sel);
      prod     = w_ext * s_ext;
      prod_ext = acc_size'(prod);
      sum      = acc_q + prod_ext;
`ifdef RESERVOIR_MAC_SATURATE_EN
      // Overflow only when both operands share a sign the sum does not
      ovf      = (acc_q[acc_size-1] == prod_ext[acc_size-1]) &&
                 (sum[acc_size-1] != acc_q[acc_size-1]);
      acc_next = ovf ? (acc_q[acc_size-1] ? acc_min : acc_max) : sum;
      sat_next = sat_q | ovf;
`else
      acc_next = sum;
`endif
   end

   // State register
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand latch, accumulator, index and result registers
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         w_q      <= '0;
         s_q      <= '0;
         idx_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
`ifdef RESERVOIR_MAC_SATURATE_EN
         sat_q    <= 1'b0;
         osat_q   <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         if (load) begin
            w_q   <= iWeights;
            s_q   <= iStates;
            idx_q <= '0;
            acc_q <= '0;
`ifdef RESERVOIR_MAC_SATURATE_EN
            sat_q <= 1'b0;
`endif
         end
         if (step) begin
            acc_q <= acc_next;
            idx_q <= idx_q + 1'b1;
`ifdef RESERVOIR_MAC_SATURATE_EN
            sat_q <= sat_next;
`endif
         end
         if (done) begin
            result_q <= acc_next;
            valid_q  <= 1'b1;
`ifdef RESERVOIR_MAC_SATURATE_EN
            osat_q   <= sat_next;
`endif
         end
      end
   end

   assign oBusy   = (state_q == StRun);
   assign oValid  = valid_q;
   assign oResult = result_q;
`ifdef RESERVOIR_MAC_SATURATE_EN
   assign oSat    = osat_q;
`else
   assign oSat    = 1'b0;
`endif

endmodule
